// File: rtl/fib_launcher.sv
// Fibonacci kernel launcher: accept job, pulse start, wait done, return result + run length (KERNEL_TIMEOUT_EN adds RUN timeout).
// Latency accept->rsp_valid = k+3 cycles (k = RUN cycles to done); req_ready only in IDLE, rsp held until rsp_ready.
module fib_launcher #(
  parameter int CYCLE_W = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [5:0]         req_n,
  input  logic [31:0]        req_a,
  input  logic [31:0]        req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_result,
  output logic [CYCLE_W-1:0] rsp_cycles,
  output logic               rsp_timeout,
  output logic               busy,
  output logic               k_r_enable,
  output logic               k_control_arr,
  output logic [5:0]         k_init_n,
  output logic [31:0]        k_init_a,
  output logic [31:0]        k_init_b,
  input  logic               k_w_enable,
  input  logic [31:0]        k_result
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

  if (TIMEOUT > (2 ** CYCLE_W) - 1) begin : g_bad_timeout
    $error("TIMEOUT does not fit in CYCLE_W bits");
  end

  state_t             state_q, state_d;
  logic [5:0]         n_q, n_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic [CYCLE_W-1:0] cnt_q, cnt_d;
  logic [31:0]        res_q, res_d;
  logic [CYCLE_W-1:0] cyc_q, cyc_d;
  logic               to_q, to_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      cyc_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      cyc_q   <= cyc_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    cyc_d   = cyc_q;
    to_d    = to_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          n_d     = req_n;
          a_d     = req_a;
          b_d     = req_b;
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        // done has priority over the timeout when both land in the same cycle
        if (k_w_enable) begin
          res_d   = k_result;
          cyc_d   = cnt_q;
          to_d    = 1'b0;
          state_d = RESP;
`ifdef KERNEL_TIMEOUT_EN
        end else if (cnt_q == CYCLE_W'(TIMEOUT)) begin
          res_d   = '0;
          cyc_d   = CYCLE_W'(TIMEOUT);
          to_d    = 1'b1;
          state_d = RESP;
`endif
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready     = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign rsp_valid     = (state_q == RESP);
  assign k_r_enable    = (state_q == LOAD);
  assign k_control_arr = 1'b0;
  assign k_init_n      = n_q;
  assign k_init_a      = a_q;
  assign k_init_b      = b_q;
  assign rsp_result    = res_q;
  assign rsp_cycles    = cyc_q;
  assign rsp_timeout   = to_q;

endmodule
